// File: rtl/logic_dispatch.sv
// Issue front end for the registered 32-bit logic unit: tracks its one-cycle latency and
// buffers tagged results in a credit-controlled FIFO so returned results are never dropped.
module logic_dispatch #(
    parameter int unsigned TAG_W = 5,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [2:0]       lu_op,
    output logic [31:0]      lu_a,
    output logic [31:0]      lu_b,
    input  logic [31:0]      lu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             busy
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DepthC = DEPTH[CW:0];
    localparam logic [CW-1:0] CountOne = 1;
    localparam logic [PW-1:0] PtrOne = 1;

    logic [2:0]       lu_op_q;
    logic [31:0]      lu_a_q, lu_b_q;
    logic             s1_valid_q, s2_valid_q;
    logic [TAG_W-1:0] s1_tag_q, s2_tag_q;
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic [31:0]      data_mem_q [DEPTH];
    logic [TAG_W-1:0] tag_mem_q [DEPTH];
    logic [CW:0]      occupancy;
    logic             accept, push, pop;

    // Credits count everything already committed to a FIFO slot, so a write never sees it full.
    always_comb begin
        occupancy = {1'b0, count_q} + {{CW{1'b0}}, s1_valid_q} + {{CW{1'b0}}, s2_valid_q};
    end

    assign in_ready  = occupancy < DepthC;
    assign accept    = in_valid & in_ready;
    assign push      = s2_valid_q;
    assign res_valid = (count_q != '0);
    assign pop       = res_valid & res_ready;
    assign busy      = s1_valid_q | s2_valid_q | res_valid;

    assign lu_op = lu_op_q;
    assign lu_a  = lu_a_q;
    assign lu_b  = lu_b_q;

    // Storage is not reset; gating the head keeps the outputs at zero while empty.
    assign res_data = res_valid ? data_mem_q[rd_ptr_q] : '0;
    assign res_tag  = res_valid ? tag_mem_q[rd_ptr_q] : '0;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CountOne;
        end else if (!push && pop) begin
            count_d = count_q - CountOne;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lu_op_q    <= '0;
            lu_a_q     <= '0;
            lu_b_q     <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_tag_q   <= '0;
            s2_tag_q   <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            if (accept) begin
                lu_op_q  <= in_op;
                lu_a_q   <= in_a;
                lu_b_q   <= in_b;
                s1_tag_q <= in_tag;
            end
            s1_valid_q <= accept;
            s2_valid_q <= s1_valid_q;
            s2_tag_q   <= s1_tag_q;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= lu_out;
            tag_mem_q[wr_ptr_q]  <= s2_tag_q;
        end
    end

endmodule

// File: tb/tb_logic_dispatch.sv
// Randomised bench for logic_dispatch with a registered logic-unit stand-in and an
// in-order transaction model of accepts, credits and result timing.
module tb_logic_dispatch;

    localparam int TAG_W = 5;
    localparam int DEPTH = 4;

    logic             clk, rst;
    logic             in_valid, in_ready;
    logic [2:0]       in_op;
    logic [31:0]      in_a, in_b;
    logic [TAG_W-1:0] in_tag;
    logic [2:0]       lu_op;
    logic [31:0]      lu_a, lu_b, lu_out;
    logic             res_valid, res_ready;
    logic [31:0]      res_data;
    logic [TAG_W-1:0] res_tag;
    logic             busy;

    logic_dispatch #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .lu_op(lu_op), .lu_a(lu_a), .lu_b(lu_b),
        .lu_out(lu_out), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_tag(res_tag), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] lu_f(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a ^ b;
            3'd2:    return ~(a & b);
            3'd3:    return a | b;
            3'd4:    return ~a;
            3'd5:    return ~(a | b);
            3'd6:    return a << b[4:0];
            default: return ~(a ^ b);
        endcase
    endfunction

    // Logic unit stand-in: one registered stage.
    initial lu_out = '0;
    always @(posedge clk) lu_out <= lu_f(lu_op, lu_a, lu_b);

    typedef struct {
        logic [31:0]      d;
        logic [TAG_W-1:0] t;
        int               k;
    } ent_t;

    ent_t        exp_q[$];
    logic [36:0] got_q[$];
    int          n_chk = 0, n_err = 0;
    int          ecount = 0, n_acc = 0, n_pop = 0;
    logic [2:0]  m_op;
    logic [31:0] m_a, m_b;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: check outputs at the negedge, then advance the model across the edge.
    task automatic cycle();
        logic             acc, pop, exp_rv;
        logic [31:0]      d_s;
        logic [TAG_W-1:0] t_s;
        @(negedge clk);
        exp_rv = (exp_q.size() != 0) && (exp_q[0].k + 2 <= ecount);
        check("in_ready", in_ready, exp_q.size() < DEPTH);
        check("busy", busy, exp_q.size() != 0);
        check("res_valid", res_valid, exp_rv);
        if (exp_rv) begin
            check("res_data", res_data, exp_q[0].d);
            check("res_tag", res_tag, exp_q[0].t);
        end
        check("lu_op", lu_op, m_op);
        check("lu_a", lu_a, m_a);
        check("lu_b", lu_b, m_b);
        acc = in_valid && (exp_q.size() < DEPTH);
        pop = res_ready && exp_rv;
        d_s = res_data;
        t_s = res_tag;
        @(posedge clk);
        #1;
        ecount++;
        if (pop) begin
            got_q.push_back({d_s, t_s});
            void'(exp_q.pop_front());
            n_pop++;
        end
        if (acc) begin
            exp_q.push_back('{lu_f(in_op, in_a, in_b), in_tag, ecount});
            m_op = in_op;
            m_a  = in_a;
            m_b  = in_b;
            n_acc++;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        res_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_op = '0;
        m_a  = '0;
        m_b  = '0;
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_res_data", res_data, 0);
        check("rst_res_tag", res_tag, 0);
        check("rst_lu", {lu_op, lu_a, lu_b}, 0);
    endtask

    task automatic rand_in();
        in_op  = 3'($urandom_range(0, 7));
        in_a   = $urandom;
        in_b   = $urandom;
        in_tag = TAG_W'($urandom_range(0, 31));
    endtask

    logic [2:0]  sweep_op [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
    logic [31:0] sweep_res[6] = '{32'h0FF00FF0, 32'h0FFF0FFF, 32'hFFF0FFF0,
                                  32'h0F0F0F0F, 32'h000F000F, 32'hF00FF00F};

    initial begin
        rst = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
        do_reset();

        // Single AND op
        got_q.delete();
        in_valid = 1'b1; in_op = 3'd0; in_a = 32'hF0F0F0F0; in_b = 32'hFF00FF00; in_tag = 5'd3;
        res_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        repeat (4) cycle();
        check("single_count", got_q.size(), 1);
        if (got_q.size() >= 1) check("single_res", got_q[0], {32'hF000F000, 5'd3});

        // Back-to-back op sweep
        got_q.delete();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_op = sweep_op[i]; in_tag = TAG_W'(i + 1);
            cycle();
        end
        in_valid = 1'b0;
        repeat (4) cycle();
        check("sweep_count", got_q.size(), 6);
        for (int i = 0; i < 6 && i < got_q.size(); i++)
            check("sweep_res", got_q[i], {sweep_res[i], TAG_W'(i + 1)});

        // Backpressure: credits cap accepts at DEPTH
        res_ready = 1'b0; in_valid = 1'b1; n_acc = 0;
        repeat (8) begin rand_in(); cycle(); end
        check("bp_accepts", n_acc, DEPTH);
        res_ready = 1'b1; n_acc = 0; n_pop = 0;
        rand_in(); cycle();
        res_ready = 1'b0;
        repeat (3) begin rand_in(); cycle(); end
        check("bp_one_pop", n_pop, 1);
        check("bp_one_more_accept", n_acc, 1);
        in_valid = 1'b0; res_ready = 1'b1;
        repeat (8) cycle();

        // Two buffered, then push and pop together across pointer wrap
        res_ready = 1'b0; in_valid = 1'b1;
        repeat (2) begin rand_in(); cycle(); end
        in_valid = 1'b0;
        repeat (3) cycle();
        res_ready = 1'b1; in_valid = 1'b1; n_pop = 0;
        repeat (24) begin rand_in(); cycle(); end
        check("wrap_pops", n_pop > 2 * DEPTH, 1);
        in_valid = 1'b0;
        repeat (6) cycle();

        // Random traffic
        repeat (300) begin
            rand_in();
            in_valid  = ($urandom_range(0, 3) != 0);
            res_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        in_valid = 1'b0; res_ready = 1'b1;
        repeat (8) cycle();
        check("drained", exp_q.size(), 0);

        // Reset with work in flight and buffered
        res_ready = 1'b0; in_valid = 1'b1;
        repeat (3) begin rand_in(); cycle(); end
        in_valid = 1'b0;
        cycle();
        check("pre_reset_busy", busy, 1);
        do_reset();
        res_ready = 1'b1; n_pop = 0;
        repeat (6) cycle();
        check("post_reset_pops", n_pop, 0);

        // Idle hold after one issue
        rand_in(); in_valid = 1'b1;
        cycle();
        in_valid = 1'b0; n_pop = 0;
        repeat (10) cycle();
        check("idle_pops", n_pop, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
